// File: rtl/mac_pkg.sv
// Shared constants and saturation helpers for the multiply-accumulate pipeline.
package mac_pkg;

    localparam logic MODE_MADD = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    localparam int INPUT_REG_DEPTH_MAX = 8;
    localparam int MULT_PIPE_DEPTH_MAX = 4;

    localparam int SAT_W = 64;
    localparam logic signed [SAT_W-1:0] SAT_ONE = 64'sd1;

    typedef struct packed {
        logic last;
        logic first;
        logic valid;
    } sband_t;

    function automatic logic signed [SAT_W-1:0] sat_limit(
        input int   w,
        input logic neg
    );
        return neg ? -(SAT_ONE <<< (w - 1))
                   : (SAT_ONE <<< (w - 1)) - SAT_ONE;
    endfunction

    function automatic logic sat_ovf(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        return (v > sat_limit(w, 1'b0)) || (v < sat_limit(w, 1'b1));
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_value(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        if (v > sat_limit(w, 1'b0)) return sat_limit(w, 1'b0);
        if (v < sat_limit(w, 1'b1)) return sat_limit(w, 1'b1);
        return v;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Enable-gated, reset-cleared delay line; DEPTH = 0 is a plain wire.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (enable_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/multiply_accumulate_pipe.sv
// Pipelined signed multiply-add / grouped accumulate with optional saturation.
module multiply_accumulate_pipe
    import mac_pkg::*;
#(
    parameter int IN_M_WIDTH      = 10,
    parameter int IN_A_WIDTH      = 20,
    parameter int OUT_WIDTH       = 24,
    parameter int INPUT_REG_DEPTH = 1,
    parameter int MULT_PIPE_DEPTH = 1,
    parameter int SATURATE        = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic                         acc_mode,
    input  logic                         acc_first,
    input  logic                         acc_last,
    input  logic signed [IN_M_WIDTH-1:0] A,
    input  logic signed [IN_M_WIDTH-1:0] B,
    input  logic signed [IN_A_WIDTH-1:0] C,
    output logic signed [OUT_WIDTH-1:0]  RES,
    output logic                         out_valid,
    output logic                         out_ovf
);

    localparam int PW = 2 * IN_M_WIDTH;
    localparam int EW = OUT_WIDTH + 1;
    localparam int CD = INPUT_REG_DEPTH + MULT_PIPE_DEPTH;

    logic [PW-1:0]                ab_r;
    logic signed [IN_M_WIDTH-1:0] a_r, b_r;
    logic signed [PW-1:0]         prod, prod_p;
    logic signed [IN_A_WIDTH-1:0] c_p;
    logic [2:0]                   sb_raw;
    sband_t                       sb;

    pipe_delay #(.WIDTH(PW), .DEPTH(INPUT_REG_DEPTH)) u_ab (
        .clk(clk), .rst(rst), .enable_i(enable),
        .d_i({A, B}), .q_o(ab_r)
    );

    assign a_r  = ab_r[PW-1:IN_M_WIDTH];
    assign b_r  = ab_r[IN_M_WIDTH-1:0];
    assign prod = a_r * b_r;

    pipe_delay #(.WIDTH(PW), .DEPTH(MULT_PIPE_DEPTH)) u_prod (
        .clk(clk), .rst(rst), .enable_i(enable),
        .d_i(prod), .q_o(prod_p)
    );

    pipe_delay #(.WIDTH(IN_A_WIDTH), .DEPTH(CD)) u_c (
        .clk(clk), .rst(rst), .enable_i(enable),
        .d_i(C), .q_o(c_p)
    );

    // Sideband rides alongside C so it meets the product at the final stage.
    pipe_delay #(.WIDTH(3), .DEPTH(CD)) u_sb (
        .clk(clk), .rst(rst), .enable_i(enable),
        .d_i({acc_last, acc_first, in_valid}), .q_o(sb_raw)
    );

    assign sb = sb_raw;

    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] res_q, res_d;
    logic                        grp_ovf_q, grp_ovf_d;
    logic                        valid_q, valid_d;
    logic                        ovf_q, ovf_d;

    logic signed [EW-1:0]        base_e, sum_e;
    logic signed [OUT_WIDTH-1:0] beat_res;
    logic                        beat_ovf, grp_ovf;

    assign base_e = (acc_mode == MODE_MADD || sb.first) ? EW'(c_p) : EW'(acc_q);
    assign sum_e  = base_e + EW'(prod_p);

    always_comb begin
        if (SATURATE != 0) begin
            beat_res = OUT_WIDTH'(sat_value(SAT_W'(sum_e), OUT_WIDTH));
            beat_ovf = sat_ovf(SAT_W'(sum_e), OUT_WIDTH);
        end else begin
            beat_res = sum_e[OUT_WIDTH-1:0];
            beat_ovf = 1'b0;
        end
    end

    assign grp_ovf = sb.first ? beat_ovf : (grp_ovf_q | beat_ovf);

    always_comb begin
        acc_d     = acc_q;
        grp_ovf_d = grp_ovf_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        if (sb.valid) begin
            if (acc_mode == MODE_MADD) begin
                res_d   = beat_res;
                ovf_d   = beat_ovf;
                valid_d = 1'b1;
            end else begin
                acc_d     = beat_res;
                grp_ovf_d = grp_ovf;
                if (sb.last) begin
                    res_d   = beat_res;
                    ovf_d   = grp_ovf;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            grp_ovf_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else if (enable) begin
            acc_q     <= acc_d;
            grp_ovf_q <= grp_ovf_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign RES       = res_q;
    assign out_valid = valid_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/multiply_accumulate_pipe.md
MULTIPLY_ACCUMULATE_PIPE -- requirements
Module: multiply_accumulate_pipe

Interface
REQ-001 Parameter IN_M_WIDTH, default 10: signed width of multiplicand inputs A and B.
REQ-002 Parameter IN_A_WIDTH, default 20: signed width of addend input C.
REQ-003 Parameter OUT_WIDTH, default 24: signed width of RES; must be >= 2*IN_M_WIDTH and >= IN_A_WIDTH.
REQ-004 Parameter INPUT_REG_DEPTH, default 1: input register stages, 0..8.
REQ-005 Parameter MULT_PIPE_DEPTH, default 1: product pipeline stages, 0..4.
REQ-006 Parameter SATURATE, default 1: 1 = clamp RES on overflow; 0 = two's-complement wrap.
REQ-007 clk  input  1: single clock; all state updates on its rising edge.
REQ-008 rst  input  1: asynchronous, active-high reset.
REQ-009 enable  input  1: global clock enable; when low, every register holds its value.
REQ-010 in_valid  input  1: A, B, C, acc_first and acc_last are valid this cycle.
REQ-011 acc_mode  input  1: quasi-static; 0 = multiply-add, 1 = accumulate.
REQ-012 acc_first, acc_last  input  1 each: first and last beat of an accumulation group.
REQ-013 A, B  input  IN_M_WIDTH signed: multiplicands.
REQ-014 C  input  IN_A_WIDTH signed: addend; in accumulate mode used only on the acc_first beat.
REQ-015 RES  output  OUT_WIDTH signed: result.
REQ-016 out_valid  output  1: RES is valid this cycle.
REQ-017 out_ovf  output  1: overflow occurred for the result or group in RES.

Function
REQ-018 Latency from an in_valid beat to its output = L = INPUT_REG_DEPTH + MULT_PIPE_DEPTH + 1 enabled cycles.
REQ-019 in_valid, acc_first and acc_last shall travel through an L-stage delay line in lockstep with the data; C is delayed INPUT_REG_DEPTH + MULT_PIPE_DEPTH stages.
REQ-020 Product = full-precision signed A*B, width 2*IN_M_WIDTH; sign-extend every operand to OUT_WIDTH+1 bits before addition.
REQ-021 Mode 0: every valid beat produces RES = sat(C + A*B), out_valid = 1 for one cycle.
REQ-022 Mode 1, acc_first beat: accumulator loads C + A*B.
REQ-023 Mode 1, other beats: accumulator loads acc + A*B.
REQ-024 Mode 1: the accumulator is held at OUT_WIDTH+1 bits, clamped per beat when SATURATE = 1, wrapped to OUT_WIDTH when SATURATE = 0.
REQ-025 Mode 1: out_valid is asserted only on the acc_last beat; RES = final accumulator value.
REQ-026 Mode 1, acc_first and acc_last on the same beat: single-beat group; RES = sat(C + A*B).
REQ-027 Mode 1, acc_first while a group is open: the open group is discarded and no output is produced for it.
REQ-028 sat(): clamp to +(2^(OUT_WIDTH-1)-1) or -2^(OUT_WIDTH-1), and set out_ovf for that output.
REQ-029 SATURATE = 0: wrap silently; out_ovf stays 0.
REQ-030 out_ovf is sticky within a group and clears on the next acc_first.
REQ-031 in_valid = 0 beats (bubbles) pass through the pipeline and do not change the accumulator.
REQ-032 enable = 0 freezes the pipeline, accumulator, RES, out_valid and out_ovf; no beat is lost or duplicated.
REQ-033 acc_mode changes are legal only when the pipeline is empty; otherwise behaviour is undefined.
REQ-034 With INPUT_REG_DEPTH = 0 and MULT_PIPE_DEPTH = 0, L = 1: registered output only.

Reset
REQ-035 On rst high, immediately clear out_valid, out_ovf, RES, the accumulator and every valid/flag delay stage to 0.
REQ-036 Data pipeline registers need not be reset; a beat in flight at reset shall never produce out_valid.
REQ-037 Operation resumes on the first enabled rising edge after rst deasserts.

Structure
REQ-038 Package mac_pkg shall hold the mode constants (MODE_MADD = 0, MODE_ACC = 1), the depth-limit constants and a saturation helper function.
REQ-039 The flag/valid delay line is one sub-module, pipe_delay (parameters WIDTH and DEPTH, with enable and rst), instantiated for the sideband bits.

Verification
REQ-040 Mode 0, depths 1/1, A = 3, B = -4, C = 100 -> RES = 88, out_valid high exactly 3 cycles later.
REQ-041 Mode 1, group of 4 beats (A,B) = (1,2),(3,4),(5,6),(7,8), C = 10 on the first beat -> single out_valid, RES = 110.
REQ-042 SATURATE = 1, OUT_WIDTH = 20, A = B = -512, C = 2^19-1 -> RES = 524287, out_ovf = 1; SATURATE = 0 -> wrapped value, out_ovf = 0.
REQ-043 enable low for 5 cycles mid-group, then high -> same RES as the uninterrupted run, out_valid delayed by exactly 5 cycles.
REQ-044 rst pulsed with 2 beats in flight -> outputs 0 asynchronously, no out_valid after release, next group correct.
REQ-045 Back-to-back single-beat groups (acc_first = acc_last = 1) on every cycle -> one out_valid per cycle with the correct per-beat result.
